// File: rtl/mem_stage_pkg.sv
// Shared types and lane helpers for the memory-access stage.
// Size/sign decode follows fn3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WB
  } state_t;

  localparam logic [2:0] FN3_B  = 3'b000;
  localparam logic [2:0] FN3_H  = 3'b001;
  localparam logic [2:0] FN3_W  = 3'b010;
  localparam logic [2:0] FN3_BU = 3'b100;
  localparam logic [2:0] FN3_HU = 3'b101;

  // fn3[1:0] alone selects the access size; 011/110/111 fall to word
  function automatic logic is_byte(input logic [2:0] fn3);
    return fn3[1:0] == 2'b00;
  endfunction

  function automatic logic is_half(input logic [2:0] fn3);
    return fn3[1:0] == 2'b01;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] fn3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      is_byte(fn3): m = 1'b0;
      is_half(fn3): m = off[0];
      default:      m = off != 2'b00;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] align_off(
    input logic [2:0] fn3,
    input logic [1:0] off
  );
    logic [1:0] o;
    o = 2'b00;
    unique case (1'b1)
      is_byte(fn3): o = off;
      is_half(fn3): o = {off[1], 1'b0};
      default:      o = 2'b00;
    endcase
    return o;
  endfunction

  function automatic logic [3:0] be_gen(
    input logic [2:0] fn3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      is_byte(fn3): be = 4'b0001 << off;
      is_half(fn3): be = off[1] ? 4'b1100 : 4'b0011;
      default:      be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_replicate(
    input logic [2:0]  fn3,
    input logic [31:0] data
  );
    logic [31:0] w;
    w = data;
    unique case (1'b1)
      is_byte(fn3): w = {4{data[7:0]}};
      is_half(fn3): w = {2{data[15:0]}};
      default:      w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane select and sign/zero extension.
// Purely combinational; offset is already aligned to the access size.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      fn3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    unique case (1'b1)
      fn3 == FN3_B:  result = {{(XLEN-8){b[7]}}, b};
      fn3 == FN3_BU: result = {{(XLEN-8){1'b0}}, b};
      fn3 == FN3_H:  result = {{(XLEN-16){h[15]}}, h};
      fn3 == FN3_HU: result = {{(XLEN-16){1'b0}}, h};
      default:       result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one req/ack data access per op, then one writeback beat.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RD_W        = 5,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [2:0]      fn3,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic [RD_W-1:0] rd,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [3:0]      dm_be,
  output logic [XLEN-1:0] dm_wdata,
  input  logic [XLEN-1:0] dm_rdata,
  input  logic            dm_ack,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            bus_err
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]   cnt;
  logic            accept;
  logic            is_mem;
  logic            trap;
  logic            timeout;
  logic [1:0]      off_in;
  logic [1:0]      off_q;
  logic [2:0]      fn3_q;
  logic            st_q;
  logic            we_q;
  logic            err_q;
  logic            dmwe_q;
  logic [XLEN-1:0] ld_res;

  assign accept  = ex_valid & ex_ready;
  assign is_mem  = mem_read | mem_write;
  assign off_in  = align_off(fn3, alu_out[1:0]);
  assign timeout = cnt == CW'(ACK_TIMEOUT - 1);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_mem & misaligned(fn3, alu_out[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign ex_ready = state == IDLE;
  assign dm_req   = state == ACCESS;
  assign dm_we    = dm_req & dmwe_q;
  assign wb_valid = state == WB;
  assign wb_we    = wb_valid & we_q;
  assign bus_err  = wb_valid & err_q;

  load_align #(
    .XLEN(XLEN)
  ) u_align (
    .rdata (dm_rdata),
    .off   (off_q),
    .fn3   (fn3_q),
    .result(ld_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = (is_mem & ~trap) ? ACCESS : WB;
      end
      ACCESS: begin
        if (dm_ack | timeout) state_nx = WB;
      end
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      off_q    <= '0;
      fn3_q    <= '0;
      st_q     <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      dmwe_q   <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            wb_rd   <= rd;
            st_q    <= mem_write;
            err_q   <= trap;
            we_q    <= reg_write & ~trap & ~mem_write;
            wb_data <= is_mem ? '0 : alu_out;
            if (is_mem & ~trap) begin
              off_q    <= off_in;
              fn3_q    <= fn3;
              dmwe_q   <= mem_write;
              dm_addr  <= {alu_out[XLEN-1:2], 2'b00};
              dm_be    <= be_gen(fn3, off_in);
              dm_wdata <= store_replicate(fn3, rs2_data);
            end
          end
        end
        ACCESS: begin
          // an ack in the final timeout cycle still completes normally
          if (dm_ack) begin
            wb_data <= st_q ? '0 : ld_res;
          end else if (timeout) begin
            err_q   <= 1'b1;
            we_q    <= 1'b0;
            wb_data <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage against a byte-level reference model.
// Misalign expectations follow MISALIGN_TRAP_EN when it is defined.
module tb_mem_access_stage;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] rs2_data;
  logic [2:0]      fn3;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic [RD_W-1:0] rd;
  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [3:0]      dm_be;
  logic [XLEN-1:0] dm_wdata;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_ack;
  logic            wb_valid;
  logic            wb_we;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            bus_err;

  always #5 clk = ~clk;

  mem_access_stage #(
    .XLEN(XLEN), .RD_W(RD_W), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_out(alu_out), .rs2_data(rs2_data), .fn3(fn3),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .rd(rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .bus_err(bus_err)
  );

  int pass_n  = 0;
  int total_n = 0;

  typedef struct {
    int          reqc;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wbv;
    logic        wbwe;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          lat;
    logic        rdy;
    logic        rdy_busy;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] f, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(f)) != 0;
  endfunction

  function automatic int m_off(input logic [2:0] f, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    return o - (o % nbytes(f));
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    int v;
    v = ((1 << nbytes(f)) - 1) << m_off(f, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = nbytes(f);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [63:0] v;
    logic [63:0] mask;
    int n;
    n = nbytes(f);
    v = {32'h0, r} >> (8 * m_off(f, a));
    if (n == 4) return v[31:0];
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if ((f == 3'b000 || f == 3'b001) && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_valid  = 1'b0;
    alu_out   = $urandom;
    rs2_data  = $urandom;
    fn3       = 3'($urandom);
    mem_read  = 1'($urandom);
    mem_write = 1'($urandom);
    reg_write = 1'($urandom);
    rd        = 5'($urandom);
  endtask

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input logic rw,
                       input logic [4:0] r, input int dly, input logic [31:0] rdat,
                       output obs_t o);
    o = '{default: 0};
    ex_valid  = 1'b1;
    alu_out   = a;
    rs2_data  = d;
    fn3       = f;
    mem_read  = ld;
    mem_write = st;
    reg_write = rw;
    rd        = r;
    step;
    idle_inputs;
    for (int c = 1; c <= 40; c++) begin
      o.rdy_busy |= ex_ready;
      if (dm_req) begin
        o.reqc++;
        o.we    = dm_we;
        o.addr  = dm_addr;
        o.be    = dm_be;
        o.wdata = dm_wdata;
        if (o.reqc == dly) begin
          dm_ack   = 1'b1;
          dm_rdata = rdat;
        end
      end
      if (wb_valid) begin
        o.wbv  = 1'b1;
        o.wbwe = wb_we;
        o.rd   = wb_rd;
        o.data = wb_data;
        o.err  = bus_err;
        o.lat  = c;
        step;
        dm_ack = 1'b0;
        o.rdy  = ex_ready;
        return;
      end
      step;
      dm_ack   = 1'b0;
      dm_rdata = $urandom;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    idle_inputs;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    reset    = 1'b1;
    step;
    step;
    total_n++;
    if ({dm_req, dm_we, dm_be, wb_valid, wb_we, bus_err} !== 9'b0)
      $display("FAIL reset_ctrl got=%b want=0",
               {dm_req, dm_we, dm_be, wb_valid, wb_we, bus_err});
    else pass_n++;
    total_n++;
    if ({dm_addr, dm_wdata, wb_rd, wb_data} !== '0)
      $display("FAIL reset_data addr=%h wdata=%h rd=%0d data=%h want=0",
               dm_addr, dm_wdata, wb_rd, wb_data);
    else pass_n++;
    total_n++;
    if (ex_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", ex_ready);
    else pass_n++;
    reset = 1'b0;
    step;
  endtask

  task automatic test_nonmem;
    obs_t o;
    do_op(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h5, 1'b1, 5'd5, 1, 32'h0, o);
    total_n++;
    if ({o.wbv, o.wbwe, o.rd, o.data, o.err} !== {1'b1, 1'b1, 5'd5, 32'h1234, 1'b0})
      $display("FAIL nonmem_wb v=%b we=%b rd=%0d data=%h err=%b want 1 1 5 00001234 0",
               o.wbv, o.wbwe, o.rd, o.data, o.err);
    else pass_n++;
    total_n++;
    if (o.lat !== 1 || o.reqc !== 0 || o.rdy !== 1'b1)
      $display("FAIL nonmem_lat lat=%0d req=%0d rdy=%b want 1 0 1", o.lat, o.reqc, o.rdy);
    else pass_n++;
  endtask

  task automatic test_lb;
    obs_t o;
    do_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b1, 5'd7, 3, 32'h80FF_0000, o);
    total_n++;
    if (o.reqc !== 3 || o.addr !== 32'h100 || o.be !== 4'b1000 || o.we !== 1'b0)
      $display("FAIL lb_bus req=%0d addr=%h be=%b we=%b want 3 00000100 1000 0",
               o.reqc, o.addr, o.be, o.we);
    else pass_n++;
    total_n++;
    if (o.data !== 32'hFFFF_FF80 || o.wbwe !== 1'b1 || o.lat !== 4 || o.rd !== 5'd7)
      $display("FAIL lb_wb data=%h we=%b lat=%0d rd=%0d want ffffff80 1 4 7",
               o.data, o.wbwe, o.lat, o.rd);
    else pass_n++;
    do_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1'b1, 5'd7, 3, 32'h80FF_0000, o);
    total_n++;
    if (o.data !== 32'h0000_0080 || o.err !== 1'b0)
      $display("FAIL lbu_wb data=%h err=%b want 00000080 0", o.data, o.err);
    else pass_n++;
  endtask

  task automatic test_sh;
    obs_t o;
    do_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 1'b1, 5'd9, 2, 32'h1, o);
    total_n++;
    if (o.we !== 1'b1 || o.be !== 4'b1100 || o.wdata !== 32'hBEEF_BEEF || o.addr !== 32'h200)
      $display("FAIL sh_bus we=%b be=%b wdata=%h addr=%h want 1 1100 beefbeef 00000200",
               o.we, o.be, o.wdata, o.addr);
    else pass_n++;
    total_n++;
    if (o.wbv !== 1'b1 || o.wbwe !== 1'b0 || o.data !== 32'h0 || o.lat !== 3)
      $display("FAIL sh_wb v=%b we=%b data=%h lat=%0d want 1 0 0 3",
               o.wbv, o.wbwe, o.data, o.lat);
    else pass_n++;
  endtask

  task automatic test_timeout;
    obs_t o;
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1, 0, 0, 32'h0, o);
    total_n++;
    if (o.reqc !== TO || o.lat !== TO + 1)
      $display("FAIL timeout_len req=%0d lat=%0d want %0d %0d", o.reqc, o.lat, TO, TO + 1);
    else pass_n++;
    total_n++;
    if ({o.wbv, o.err, o.wbwe, o.data, o.rdy} !== {1'b1, 1'b1, 1'b0, 32'h0, 1'b1})
      $display("FAIL timeout_wb v=%b err=%b we=%b data=%h rdy=%b want 1 1 0 0 1",
               o.wbv, o.err, o.wbwe, o.data, o.rdy);
    else pass_n++;
    // ack in the final timeout cycle must complete the access
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 1'b1, 1, TO, 32'hCAFE_F00D, o);
    total_n++;
    if (o.err !== 1'b0 || o.data !== 32'hCAFE_F00D || o.wbwe !== 1'b1 || o.lat !== TO + 1)
      $display("FAIL timeout_ack err=%b data=%h we=%b lat=%0d want 0 cafef00d 1 %0d",
               o.err, o.data, o.wbwe, o.lat, TO + 1);
    else pass_n++;
  endtask

  task automatic test_misalign;
    obs_t o;
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 1'b1, 5'd3, 2, 32'h1122_3344, o);
`ifdef MISALIGN_TRAP_EN
    total_n++;
    if (o.reqc !== 0 || o.lat !== 1 || o.err !== 1'b1 || o.wbwe !== 1'b0)
      $display("FAIL misalign_trap req=%0d lat=%0d err=%b we=%b want 0 1 1 0",
               o.reqc, o.lat, o.err, o.wbwe);
    else pass_n++;
`else
    total_n++;
    if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.data !== 32'h1122_3344 ||
        o.err !== 1'b0 || o.wbwe !== 1'b1)
      $display("FAIL misalign_align addr=%h be=%b data=%h err=%b we=%b want 100 1111 11223344 0 1",
               o.addr, o.be, o.data, o.err, o.wbwe);
    else pass_n++;
`endif
  endtask

  task automatic test_reset_mid;
    int seen;
    ex_valid  = 1'b1;
    alu_out   = 32'h0000_0300;
    fn3       = 3'b010;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    reg_write = 1'b1;
    rd        = 5'd4;
    step;
    idle_inputs;
    step;
    total_n++;
    if (dm_req !== 1'b1) $display("FAIL rstmid_req_pre got=%b want=1", dm_req);
    else pass_n++;
    #1 reset = 1'b1;
    #1;
    total_n++;
    if (dm_req !== 1'b0) $display("FAIL rstmid_req_drop got=%b want=0", dm_req);
    else pass_n++;
    step;
    step;
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 5; i++) begin
      if (wb_valid) seen++;
      step;
    end
    total_n++;
    if (seen !== 0 || ex_ready !== 1'b1)
      $display("FAIL rstmid_after wb_seen=%0d ready=%b want 0 1", seen, ex_ready);
    else pass_n++;
  endtask

  task automatic test_back_to_back;
    obs_t o;
    logic        ld, st, rw, mis, err, exp_we;
    logic [2:0]  f;
    logic [31:0] a, d, rdat, exp_data;
    logic [4:0]  r;
    int          dly, exp_req, exp_lat;
    for (int n = 0; n < 60; n++) begin
      f    = 3'($urandom);
      a    = $urandom;
      d    = $urandom;
      rdat = $urandom;
      rw   = 1'($urandom);
      r    = 5'($urandom);
      dly  = $urandom_range(1, 5);
      case ($urandom_range(0, 2))
        0:       begin ld = 1'b0; st = 1'b0; end
        1:       begin ld = 1'b1; st = 1'($urandom_range(0, 3) == 0); end
        default: begin ld = 1'($urandom); st = 1'b1; end
      endcase
      do_op(ld, st, f, a, d, rw, r, dly, rdat, o);
      mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (ld | st) && m_mis(f, a);
`endif
      err      = mis;
      exp_req  = (ld | st) && !mis ? dly : 0;
      exp_lat  = exp_req + 1;
      exp_we   = rw && !st && !err;
      exp_data = !(ld | st) ? a : (st || err) ? 32'h0 : m_load(f, a, rdat);
      total_n++;
      if ({o.wbv, o.wbwe, o.rd, o.data, o.err, o.rdy, o.rdy_busy} !==
          {1'b1, exp_we, r, exp_data, err, 1'b1, 1'b0} || o.lat !== exp_lat)
        $display("FAIL rand_wb[%0d] v=%b we=%b rd=%0d data=%h err=%b lat=%0d want we=%b rd=%0d data=%h err=%b lat=%0d",
                 n, o.wbv, o.wbwe, o.rd, o.data, o.err, o.lat,
                 exp_we, r, exp_data, err, exp_lat);
      else pass_n++;
      if (exp_req != 0) begin
        total_n++;
        if (o.reqc !== exp_req || o.we !== st || o.addr !== {a[31:2], 2'b00} ||
            o.be !== m_be(f, a) || (st && o.wdata !== m_wdata(f, d)))
          $display("FAIL rand_bus[%0d] req=%0d we=%b addr=%h be=%b wdata=%h want %0d %b %h %b %h",
                   n, o.reqc, o.we, o.addr, o.be, o.wdata, exp_req, st,
                   {a[31:2], 2'b00}, m_be(f, a), m_wdata(f, d));
        else pass_n++;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    idle_inputs;
    test_reset;
    test_nonmem;
    test_lb;
    test_sh;
    test_timeout;
    test_misalign;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
